multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle sequencer for the uniciclo CPU datapath, reworked to share one memory port between instruction fetch and data access. Decodes the latched instruction fields (opcode, i, s, rd, cond) and holds an internal NZCV flags register. Drives the datapath enables and muxes state by state, and handshakes every memory access through mem_req/mem_ready. A wait-cycle watchdog bounds each memory access.

## Interface
- WAIT_MAX, default 255: maximum wait cycles allowed per memory access before the access is aborted.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  2  instruction class: 0 = data, 1 = memory, 2 = branch, 3 = illegal.
- cond  in  4  condition field.
- i  in  1  immediate bit.
- s  in  1  data class: set flags; memory class: 1 = load, 0 = store.
- rd  in  4  destination register.
- alu_flags  in  4  ALU result flags {N,Z,C,V}.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access active.
- mem_we  out  1  the active access is a write.
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALU result register.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- mdr_we  out  1  load-data register capture.
- reg_we  out  1  register file write.
- reg_src  out  1  0 for a register-operand data op, else 1.
- imm_src  out  1  1 in the BRANCH state.
- alu_src_a  out  1  ALU A operand: 0 = register, 1 = PC.
- alu_src_b  out  2  ALU B operand: 0 = register, 1 = immediate, 2 = constant 4.
- result_src  out  2  writeback source: 0 = ALU register, 1 = MDR, 2 = ALU direct.
- flags  out  4  registered NZCV.
- cond_fail  out  1  one-cycle pulse when an instruction is squashed.
- illegal  out  1  one-cycle pulse on opcode 3.
- bus_err  out  1  one-cycle pulse on watchdog timeout.

## Operation
- States and transitions:
  - FETCH → DECODE.
  - DECODE → EXEC, MEM_ADDR or BRANCH.
  - EXEC → ALU_WB → FETCH.
  - MEM_ADDR → MEM_RD → MEM_WB → FETCH for a load (s = 1).
  - MEM_ADDR → MEM_WR → FETCH for a store (s = 0).
  - BRANCH → FETCH.
- FETCH:
  - Drives mem_req = 1, adr_src = 0, alu_src_a = 1, alu_src_b = 2, result_src = 2.
  - ir_we and pc_we assert only in the cycle mem_ready = 1; the state then advances.
- DECODE: evaluates cond against the flags register.
  - On a condition fail, returns to FETCH and pulses cond_fail. No reg_we, mem_we or flags update occurs.
  - On opcode 3, returns to FETCH and pulses illegal. Illegal takes priority over the condition check.
- Condition codes: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, 10 GE, 11 LT, 12 GT, 13 LE, 14 AL, 15 never.
- EXEC: alu_src_b = i ? 1 : 0.
- ALU_WB:
  - reg_we = 1 unless rd == 15. When rd == 15, pc_we = 1 and reg_we = 0.
  - Flags load from alu_flags when s = 1.
- MEM_ADDR: alu_src_b = (i == 0) ? 1 : 0.
- MEM_RD: mem_req = 1, adr_src = 1. mdr_we asserts in the mem_ready cycle.
- MEM_WB: reg_we = 1, result_src = 1.
- MEM_WR: mem_req = 1, mem_we = 1, adr_src = 1. Leaves on mem_ready.
- BRANCH: imm_src = 1, alu_src_a = 1, alu_src_b = 1, result_src = 2, pc_we = 1.
- Watchdog:
  - Counter clears on entry to each memory state and increments per cycle with mem_ready = 0.
  - When it reaches WAIT_MAX with mem_ready still 0: pulse bus_err, drop mem_req, go to FETCH.
  - The aborted instruction has no side effects. PC is not advanced on a fetch abort.
- Width: counter is $clog2(WAIT_MAX+1) bits and saturates; it never wraps.

## Timing
- Outputs are Moore decodes of the state register. Exceptions are ir_we, pc_we (FETCH only), mdr_we and the state advance, which are qualified by same-cycle mem_ready.
- While rst = 1, every output is 0. On the first edge with rst = 1, state becomes FETCH, flags become 0 and the counter becomes 0.
- Assertion of rst mid-access abandons the access; mem_req drops in the next cycle.
- Latency with zero wait states: data op 4 cycles, load 5, store 4, branch 3, squashed or illegal instruction 2. Each wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- mem_ready and a timeout in the same cycle: mem_ready wins.

## Structure
- Shared package cpu_ctrl_pkg contains:
  - The state enum.
  - Opcode constants (OP_DATA, OP_MEM, OP_BR).
  - Condition-code constants.
  - alu_src_b and result_src encodings.
- Sub-module cond_check: combinational function of cond and flags producing pass.
- Flags register and watchdog live in the controller.

## Test plan
- Reset, then a data op (opcode 0, i 1, s 1, cond 14, rd 3, alu_flags 4'b0100) with mem_ready tied 1:
  - States FETCH, DECODE, EXEC, ALU_WB.
  - reg_we high only in cycle 4.
  - flags = 4'b0100 afterwards.
- Load (opcode 1, s 1, i 0) with 3 wait cycles in MEM_RD:
  - mem_req held 4 cycles.
  - mdr_we one cycle, coincident with mem_ready.
  - reg_we with result_src = 1 in the next cycle.
  - Total 8 cycles.
- Conditional branch on flags Z = 0:
  - cond 0 gives cond_fail in DECODE, no pc_we outside FETCH, back to FETCH in cycle 3.
  - cond 1 asserts pc_we in BRANCH with imm_src = 1.
- Store with mem_ready held low and WAIT_MAX = 4:
  - bus_err pulses after 4 wait cycles and mem_we never coincides with mem_ready.
  - Next state is FETCH.
- Opcode 3:
  - illegal pulse in DECODE, no reg_we or mem_we.
  - Data op with rd = 15 produces pc_we = 1 and reg_we = 0 in ALU_WB.
- Assert rst during MEM_RD wait:
  - All outputs go to 0 while rst = 1.
  - After release the first cycle is FETCH with mem_req = 1 and flags = 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding, instruction
// field constants and datapath mux encodings.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  localparam logic [1:0] OP_DATA = 2'd0;
  localparam logic [1:0] OP_MEM  = 2'd1;
  localparam logic [1:0] OP_BR   = 2'd2;
  localparam logic [1:0] OP_ILL  = 2'd3;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Flag bit positions inside the {N,Z,C,V} vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] RD_PC = 4'd15;

  localparam logic [1:0] ASB_REG  = 2'd0;
  localparam logic [1:0] ASB_IMM  = 2'd1;
  localparam logic [1:0] ASB_FOUR = 2'd2;

  localparam logic [1:0] RS_ALUREG = 2'd0;
  localparam logic [1:0] RS_MDR    = 2'd1;
  localparam logic [1:0] RS_ALU    = 2'd2;

  // States that own the shared memory port and are bounded by the watchdog.
  function automatic logic is_mem_state(state_t st);
    return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: decides whether an instruction with
// condition field i_cond executes under the current NZCV flags.
module cond_check
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      CC_EQ: o_pass = w_z;
      CC_NE: o_pass = !w_z;
      CC_CS: o_pass = w_c;
      CC_CC: o_pass = !w_c;
      CC_MI: o_pass = w_n;
      CC_PL: o_pass = !w_n;
      CC_VS: o_pass = w_v;
      CC_VC: o_pass = !w_v;
      CC_HI: o_pass = w_c && !w_z;
      CC_LS: o_pass = !w_c || w_z;
      CC_GE: o_pass = (w_n == w_v);
      CC_LT: o_pass = (w_n != w_v);
      CC_GT: o_pass = !w_z && (w_n == w_v);
      CC_LE: o_pass = w_z || (w_n != w_v);
      CC_AL: o_pass = 1'b1;
      CC_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer sharing one memory port between fetch and data access,
// with an NZCV flags register and a per-access wait-cycle watchdog.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] opcode,
  input  logic [3:0] cond,
  input  logic       i,
  input  logic       s,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       mdr_we,
  output logic       reg_we,
  output logic       reg_src,
  output logic       imm_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] flags,
  output logic       cond_fail,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] o_dbg_state
);

  localparam int            CW   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_flags;
  logic [CW-1:0] r_wcnt;

  logic       w_pass;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_flags_we;
  logic       w_mem_req, w_mem_we, w_adr_src, w_ir_we, w_pc_we, w_mdr_we;
  logic       w_reg_we, w_reg_src, w_imm_src, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_result_src;
  logic       w_cond_fail, w_illegal, w_bus_err;

  cond_check u_cond_check (
    .i_cond  (cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  // Memory handshake: mem_req stays high for the whole access; the access
  // completes in the cycle where mem_req and mem_ready are both high.
  // mem_ready is a don't-care whenever mem_req is low.
  assign w_mem_state = is_mem_state(r_state);
  assign w_timeout   = w_mem_state && !mem_ready && (r_wcnt == WMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (w_flags_we) begin
      r_flags <= alu_flags;
    end
  end

  // Counts wait cycles of the current access; cleared whenever the access
  // completes, aborts, or the controller is outside a memory state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_mem_state && !mem_ready && !w_timeout) begin
      r_wcnt <= (r_wcnt == WMAX) ? r_wcnt : r_wcnt + CW'(1);
    end else begin
      r_wcnt <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_mdr_we     = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_src    = !((opcode == OP_DATA) && !i);
    w_imm_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = ASB_REG;
    w_result_src = RS_ALUREG;
    w_cond_fail  = 1'b0;
    w_illegal    = 1'b0;
    w_bus_err    = 1'b0;
    w_flags_we   = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = ASB_FOUR;
        w_result_src = RS_ALU;
        if (mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end
      end

      S_DECODE: begin
        // Illegal opcodes are reported even when the condition would fail.
        if (opcode == OP_ILL) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else if (!w_pass) begin
          w_cond_fail = 1'b1;
          w_next      = S_FETCH;
        end else begin
          case (opcode)
            OP_DATA: w_next = S_EXEC;
            OP_MEM:  w_next = S_MEM_ADDR;
            OP_BR:   w_next = S_BRANCH;
            default: w_next = S_FETCH;
          endcase
        end
      end

      S_EXEC: begin
        w_alu_src_b = i ? ASB_IMM : ASB_REG;
        w_next      = S_ALU_WB;
      end

      S_ALU_WB: begin
        w_result_src = RS_ALUREG;
        if (rd == RD_PC) begin
          w_pc_we = 1'b1;
        end else begin
          w_reg_we = 1'b1;
        end
        w_flags_we = s;
        w_next     = S_FETCH;
      end

      S_MEM_ADDR: begin
        // Memory ops use the inverted sense of i for the offset operand.
        w_alu_src_b = i ? ASB_REG : ASB_IMM;
        w_next      = s ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) begin
          w_mdr_we = 1'b1;
          w_next   = S_MEM_WB;
        end else if (w_timeout) begin
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end
      end

      S_MEM_WB: begin
        w_reg_we     = 1'b1;
        w_result_src = RS_MDR;
        w_next       = S_FETCH;
      end

      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end
      end

      S_BRANCH: begin
        w_imm_src    = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = ASB_IMM;
        w_result_src = RS_ALU;
        w_pc_we      = 1'b1;
        w_next       = S_FETCH;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset forces every output low, including mid-access.
  assign mem_req     = w_mem_req   & ~rst;
  assign mem_we      = w_mem_we    & ~rst;
  assign adr_src     = w_adr_src   & ~rst;
  assign ir_we       = w_ir_we     & ~rst;
  assign pc_we       = w_pc_we     & ~rst;
  assign mdr_we      = w_mdr_we    & ~rst;
  assign reg_we      = w_reg_we    & ~rst;
  assign reg_src     = w_reg_src   & ~rst;
  assign imm_src     = w_imm_src   & ~rst;
  assign alu_src_a   = w_alu_src_a & ~rst;
  assign alu_src_b   = rst ? 2'b00 : w_alu_src_b;
  assign result_src  = rst ? 2'b00 : w_result_src;
  assign flags       = rst ? 4'b0000 : r_flags;
  assign cond_fail   = w_cond_fail & ~rst;
  assign illegal     = w_illegal   & ~rst;
  assign bus_err     = w_bus_err   & ~rst;
  assign o_dbg_state = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// go through a scoreboard queue and are compared on the falling edge.
module tb_multicycle_controller;
  import cpu_ctrl_pkg::*;

  localparam int WAIT_MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] opcode;
  logic [3:0] cond;
  logic       i, s;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       mem_req, mem_we, adr_src, ir_we, pc_we, mdr_we, reg_we;
  logic       reg_src, imm_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] flags;
  logic       cond_fail, illegal, bus_err;
  logic [3:0] dbg_state;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_we;
    logic       pc_we;
    logic       mdr_we;
    logic       reg_we;
    logic       reg_src;
    logic       imm_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] flags;
    logic       cond_fail;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;
  } obs_t;

  localparam int OW = $bits(obs_t);

  logic [OW-1:0] exp_q[$];
  obs_t          w_obs;
  logic [3:0]    exp_flags;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .cond        (cond),
    .i           (i),
    .s           (s),
    .rd          (rd),
    .alu_flags   (alu_flags),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .mdr_we      (mdr_we),
    .reg_we      (reg_we),
    .reg_src     (reg_src),
    .imm_src     (imm_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .flags       (flags),
    .cond_fail   (cond_fail),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .o_dbg_state (dbg_state)
  );

  always_comb begin
    w_obs            = '0;
    w_obs.mem_req    = mem_req;
    w_obs.mem_we     = mem_we;
    w_obs.adr_src    = adr_src;
    w_obs.ir_we      = ir_we;
    w_obs.pc_we      = pc_we;
    w_obs.mdr_we     = mdr_we;
    w_obs.reg_we     = reg_we;
    w_obs.reg_src    = reg_src;
    w_obs.imm_src    = imm_src;
    w_obs.alu_src_a  = alu_src_a;
    w_obs.alu_src_b  = alu_src_b;
    w_obs.result_src = result_src;
    w_obs.flags      = flags;
    w_obs.cond_fail  = cond_fail;
    w_obs.illegal    = illegal;
    w_obs.bus_err    = bus_err;
    w_obs.state      = dbg_state;
  end

  // State-by-state output table; mem_ready-qualified strobes and the
  // DECODE/abort pulses are added by the caller.
  function automatic obs_t moore(state_t st);
    obs_t e;
    e         = '0;
    e.state   = st;
    e.flags   = exp_flags;
    e.reg_src = (opcode == 2'd0 && i == 1'b0) ? 1'b0 : 1'b1;
    case (st)
      S_FETCH: begin
        e.mem_req = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
      end
      S_EXEC:     e.alu_src_b = i ? 2'd1 : 2'd0;
      S_ALU_WB: begin
        e.reg_we = (rd != 4'd15); e.pc_we = (rd == 4'd15);
      end
      S_MEM_ADDR: e.alu_src_b = (i == 1'b0) ? 2'd1 : 2'd0;
      S_MEM_RD: begin
        e.mem_req = 1'b1; e.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        e.reg_we = 1'b1; e.result_src = 2'd1;
      end
      S_MEM_WR: begin
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1;
      end
      S_BRANCH: begin
        e.imm_src = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'd1;
        e.result_src = 2'd2; e.pc_we = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input obs_t e);
    obs_t want;
    exp_q.push_back(e);
    @(negedge clk);
    want = obs_t'(exp_q.pop_front());
    n_chk++;
    assert (w_obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, w_obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [3:0] c, input logic ii,
                           input logic ss, input logic [3:0] r, input logic [3:0] af);
    opcode = op; cond = c; i = ii; s = ss; rd = r; alu_flags = af;
  endtask

  task automatic do_fetch(input int waits);
    obs_t e;
    mem_ready = 1'b0;
    for (int k = 0; k < waits; k++) chk("fetch_wait", moore(S_FETCH));
    mem_ready = 1'b1;
    e = moore(S_FETCH);
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    chk("fetch", e);
  endtask

  task automatic run_data();
    do_fetch(0);
    chk("decode_data", moore(S_DECODE));
    chk("exec", moore(S_EXEC));
    chk("alu_wb", moore(S_ALU_WB));
    if (s) exp_flags = alu_flags;
  endtask

  task automatic cond_sweep();
    obs_t e;
    for (int c = 0; c < 16; c++) begin
      set_instr(2'd2, 4'(c), 1'b0, 1'b0, 4'd0, 4'd0);
      do_fetch(0);
      e = moore(S_DECODE);
      e.cond_fail = !cond_ok(4'(c), exp_flags);
      chk("decode_branch", e);
      if (cond_ok(4'(c), exp_flags)) chk("branch", moore(S_BRANCH));
    end
  endtask

  initial begin
    obs_t e;
    rst       = 1'b1;
    mem_ready = 1'b1;
    exp_flags = 4'b0000;
    set_instr(2'd0, 4'd14, 1'b1, 1'b1, 4'd3, 4'b0100);
    chk("reset0", '0);
    chk("reset1", '0);
    rst = 1'b0;

    // Data op, zero wait states: flags pick up alu_flags in ALU_WB.
    run_data();

    // Load with three wait cycles in MEM_RD.
    set_instr(2'd1, 4'd14, 1'b0, 1'b1, 4'd2, 4'b1111);
    do_fetch(0);
    chk("decode_load", moore(S_DECODE));
    chk("mem_addr_load", moore(S_MEM_ADDR));
    mem_ready = 1'b0;
    repeat (3) chk("rd_wait", moore(S_MEM_RD));
    mem_ready = 1'b1;
    e = moore(S_MEM_RD);
    e.mdr_we = 1'b1;
    chk("rd_done", e);
    chk("mem_wb", moore(S_MEM_WB));

    // rd = 15 redirects the writeback to the PC; flags become N only.
    set_instr(2'd0, 4'd14, 1'b0, 1'b1, 4'd15, 4'b1000);
    run_data();
    cond_sweep();

    set_instr(2'd0, 4'd14, 1'b1, 1'b1, 4'd4, 4'b0011);
    run_data();
    cond_sweep();

    // Store with mem_ready held low: abort after WAIT_MAX wait cycles.
    set_instr(2'd1, 4'd14, 1'b1, 1'b0, 4'd6, 4'b0000);
    do_fetch(0);
    chk("decode_store", moore(S_DECODE));
    chk("mem_addr_store", moore(S_MEM_ADDR));
    mem_ready = 1'b0;
    repeat (WAIT_MAX) chk("wr_wait", moore(S_MEM_WR));
    e = moore(S_MEM_WR);
    e.bus_err = 1'b1;
    chk("wr_timeout", e);

    // Same store, ready arrives exactly at the timeout cycle.
    do_fetch(0);
    chk("decode_store2", moore(S_DECODE));
    chk("mem_addr_store2", moore(S_MEM_ADDR));
    mem_ready = 1'b0;
    repeat (WAIT_MAX) chk("wr_wait2", moore(S_MEM_WR));
    mem_ready = 1'b1;
    chk("wr_ready_wins", moore(S_MEM_WR));

    // Fetch abort: stays in FETCH, watchdog restarts for the retry.
    set_instr(2'd0, 4'd14, 1'b1, 1'b0, 4'd5, 4'b1111);
    mem_ready = 1'b0;
    repeat (WAIT_MAX) chk("fetch_wait_abort", moore(S_FETCH));
    e = moore(S_FETCH);
    e.bus_err = 1'b1;
    chk("fetch_timeout", e);
    do_fetch(WAIT_MAX);
    chk("decode_retry", moore(S_DECODE));
    chk("exec_retry", moore(S_EXEC));
    chk("alu_wb_retry", moore(S_ALU_WB));

    // Illegal opcode wins over a never-true condition.
    set_instr(2'd3, 4'd15, 1'b0, 1'b1, 4'd7, 4'b0000);
    do_fetch(0);
    e = moore(S_DECODE);
    e.illegal = 1'b1;
    chk("illegal", e);

    // Reset in the middle of a load wait.
    set_instr(2'd1, 4'd14, 1'b0, 1'b1, 4'd2, 4'b0000);
    do_fetch(0);
    chk("decode_load2", moore(S_DECODE));
    chk("mem_addr_load2", moore(S_MEM_ADDR));
    mem_ready = 1'b0;
    repeat (2) chk("rd_wait2", moore(S_MEM_RD));
    rst = 1'b1;
    chk("rst_mid0", '0);
    chk("rst_mid1", '0);
    rst = 1'b0;
    exp_flags = 4'b0000;
    chk("post_rst_fetch", moore(S_FETCH));
    do_fetch(0);
    chk("post_rst_decode", moore(S_DECODE));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
